// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus: slot map, default geometry and populated-slot mask.
package bus_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int BUS_N_SRC = 24;
    localparam int BUS_SEL_W = 5;
    localparam int BUS_CNT_W = 8;

    localparam int R0  = 0;
    localparam int R1  = 1;
    localparam int R2  = 2;
    localparam int R3  = 3;
    localparam int R4  = 4;
    localparam int R5  = 5;
    localparam int R6  = 6;
    localparam int R7  = 7;
    localparam int R8  = 8;
    localparam int R9  = 9;
    localparam int R10 = 10;
    localparam int R11 = 11;
    localparam int R12 = 12;
    localparam int R13 = 13;
    localparam int R14 = 14;
    localparam int R15 = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int C      = 23;

    // INPORT stays unpopulated until the I/O block is integrated.
    localparam logic [BUS_N_SRC-1:0] BUS_SRC_MASK = 24'hBF_FFFF;

endpackage

// File: rtl/bus_mux_reg_onehot_prio_enc.sv
// Lowest-index-wins priority encoder over an enable vector, with "any" and "more than one" flags.
module onehot_prio_enc #(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any,
    output logic         o_multi
);

    // Scan downwards so the last hit, i.e. the lowest set bit, is what remains.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

    assign o_any   = |i_vec;
    assign o_multi = |(i_vec & (i_vec - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus mux: priority resolution of one-hot driver enables, bus hold,
// and multi-driver / unpopulated-slot conflict detection with a sticky flag and saturating count.
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int                WIDTH       = BUS_WIDTH,
    parameter int                N_SRC       = BUS_N_SRC,
    parameter int                SEL_W       = BUS_SEL_W,
    parameter int                PIPE        = 1,
    parameter logic [N_SRC-1:0]  SRC_MASK    = BUS_SRC_MASK,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   hold,
    input  logic                   conflict_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   bus_valid,
    output logic                   conflict,
    output logic                   conflict_flag,
    output logic [BUS_CNT_W-1:0]   conflict_cnt
);

    // Handshake: bus_valid qualifies bus_out/bus_sel in the cycle it is high; there is no
    // ready, consumers simply sample the bus every cycle and ignore it while bus_valid is 0.

    logic [N_SRC-1:0]     w_en;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 w_valid_nxt;
    logic                 w_multi;
    logic [WIDTH-1:0]     w_data_nxt;
    logic                 w_conflict;
    logic [BUS_CNT_W-1:0] w_cnt_base;

    logic [WIDTH-1:0]     r_bus_out;
    logic [SEL_W-1:0]     r_bus_sel;
    logic                 r_bus_valid;
    logic                 r_conflict;
    logic                 r_conflict_flag;
    logic [BUS_CNT_W-1:0] r_conflict_cnt;

    assign w_en = src_out & SRC_MASK;

    onehot_prio_enc #(
        .N (N_SRC),
        .W (SEL_W)
    ) u_enc (
        .i_vec   (w_en),
        .o_idx   (w_sel_nxt),
        .o_any   (w_valid_nxt),
        .o_multi (w_multi)
    );

    // Only the winning slot is ever read, so X on any other slot cannot reach the bus.
    assign w_data_nxt = w_valid_nxt ? src_data[w_sel_nxt*WIDTH +: WIDTH] : DEFAULT_VAL;
    assign w_conflict = w_multi | (|(src_out & ~SRC_MASK));

    // A clear in the same cycle as a new conflict restarts the count at 1.
    assign w_cnt_base = conflict_clr ? '0 : r_conflict_cnt;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_bus_out       <= DEFAULT_VAL;
            r_bus_sel       <= '0;
            r_bus_valid     <= 1'b0;
            r_conflict      <= 1'b0;
            r_conflict_flag <= 1'b0;
            r_conflict_cnt  <= '0;
        end else begin
            if (!hold) begin
                r_bus_out   <= w_data_nxt;
                r_bus_sel   <= w_sel_nxt;
                r_bus_valid <= w_valid_nxt;
            end
            r_conflict <= w_conflict;
            if (w_conflict) begin
                r_conflict_flag <= 1'b1;
                r_conflict_cnt  <= (w_cnt_base == {BUS_CNT_W{1'b1}}) ? w_cnt_base
                                                                       : w_cnt_base + 1'b1;
            end else if (conflict_clr) begin
                r_conflict_flag <= 1'b0;
                r_conflict_cnt  <= '0;
            end
        end
    end

    // The same registers serve as the output stage (PIPE=1) or as the hold capture (PIPE=0).
    if (PIPE != 0) begin : g_pipe
        assign bus_out   = r_bus_out;
        assign bus_sel   = r_bus_sel;
        assign bus_valid = r_bus_valid;
        assign conflict  = r_conflict;
    end else begin : g_comb
        assign bus_out   = hold ? r_bus_out   : w_data_nxt;
        assign bus_sel   = hold ? r_bus_sel   : w_sel_nxt;
        assign bus_valid = hold ? r_bus_valid : w_valid_nxt;
        assign conflict  = w_conflict;
    end

    assign conflict_flag = r_conflict_flag;
    assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: a registered (PIPE=1) and a combinational (PIPE=0) instance on shared stimulus.
module tb_bus_mux_reg;

    localparam int W = 32;
    localparam int N = 24;
    localparam int SW = 5;
    localparam logic [N-1:0] MASK = 24'hBF_FFFF;

    logic            clock;
    logic            clear;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_out;
    logic            hold;
    logic            conflict_clr;

    logic [W-1:0]    p1_bus_out, p0_bus_out;
    logic [SW-1:0]   p1_bus_sel, p0_bus_sel;
    logic            p1_bus_valid, p0_bus_valid;
    logic            p1_conflict, p0_conflict;
    logic            p1_flag, p0_flag;
    logic [7:0]      p1_cnt, p0_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: value on the bus after the last edge, conflict pulse, sticky flag, count.
    logic [W-1:0]    m_out;
    logic [SW-1:0]   m_sel;
    logic            m_valid;
    logic            m_conf;
    logic            m_flag;
    int              m_cnt;

    bus_mux_reg #(.WIDTH(W), .N_SRC(N), .SEL_W(SW), .PIPE(1), .SRC_MASK(MASK), .DEFAULT_VAL('0)) u_p1 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out), .hold(hold),
        .conflict_clr(conflict_clr), .bus_out(p1_bus_out), .bus_sel(p1_bus_sel),
        .bus_valid(p1_bus_valid), .conflict(p1_conflict), .conflict_flag(p1_flag),
        .conflict_cnt(p1_cnt)
    );

    bus_mux_reg #(.WIDTH(W), .N_SRC(N), .SEL_W(SW), .PIPE(0), .SRC_MASK(MASK), .DEFAULT_VAL('0)) u_p0 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out), .hold(hold),
        .conflict_clr(conflict_clr), .bus_out(p0_bus_out), .bus_sel(p0_bus_sel),
        .bus_valid(p0_bus_valid), .conflict(p0_conflict), .conflict_flag(p0_flag),
        .conflict_cnt(p0_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int idx, input logic [W-1:0] val);
        src_data[idx*W +: W] = val;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) set_slot(i, $urandom);
    endtask

    // Bus rules applied directly: first populated enabled slot wins; any enabled hole or a
    // second populated enable is a conflict.
    task automatic model_nxt(output logic [W-1:0] d, output logic [SW-1:0] s,
                             output logic v, output logic c);
        int n_legal;
        d = '0; s = '0; v = 1'b0; c = 1'b0; n_legal = 0;
        for (int i = 0; i < N; i++) begin
            if (src_out[i]) begin
                if (!MASK[i]) begin
                    c = 1'b1;
                end else begin
                    n_legal++;
                    if (!v) begin
                        v = 1'b1;
                        s = i[SW-1:0];
                        d = src_data[i*W +: W];
                    end
                end
            end
        end
        if (n_legal > 1) c = 1'b1;
    endtask

    // One clock: check the combinational instance before the edge, advance the model at the
    // edge, then check the registered instance and the shared counters after it.
    task automatic cycle();
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic          v, c;
        model_nxt(d, s, v, c);
        #1;
        if (clear) begin
            check("p0_bus_out",   p0_bus_out,   hold ? m_out : d);
            check("p0_bus_sel",   W'(p0_bus_sel), W'(hold ? m_sel : s));
            check("p0_bus_valid", W'(p0_bus_valid), W'(hold ? m_valid : v));
            check("p0_conflict",  W'(p0_conflict), W'(c));
        end
        @(posedge clock);
        if (!clear) begin
            m_out = '0; m_sel = '0; m_valid = 1'b0; m_conf = 1'b0; m_flag = 1'b0; m_cnt = 0;
        end else begin
            if (!hold) begin
                m_out = d; m_sel = s; m_valid = v;
            end
            m_conf = c;
            if (c) begin
                m_flag = 1'b1;
                m_cnt  = (conflict_clr ? 0 : m_cnt) + 1;
                if (m_cnt > 255) m_cnt = 255;
            end else if (conflict_clr) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end
        end
        #1;
        check("p1_bus_out",   p1_bus_out, m_out);
        check("p1_bus_sel",   W'(p1_bus_sel), W'(m_sel));
        check("p1_bus_valid", W'(p1_bus_valid), W'(m_valid));
        check("p1_conflict",  W'(p1_conflict), W'(m_conf));
        check("p1_flag",      W'(p1_flag), W'(m_flag));
        check("p1_cnt",       W'(p1_cnt), W'(m_cnt));
        check("p0_flag",      W'(p0_flag), W'(m_flag));
        check("p0_cnt",       W'(p0_cnt), W'(m_cnt));
    endtask

    initial begin
        int r;
        m_out = '0; m_sel = '0; m_valid = 1'b0; m_conf = 1'b0; m_flag = 1'b0; m_cnt = 0;
        src_data = '0;
        fill_random();
        hold = 1'b0;
        conflict_clr = 1'b0;

        // Reset with an enable present.
        clear = 1'b0;
        src_out = 24'(1) << 3;
        cycle();
        check("rst_bus_out", p1_bus_out, 32'h0);
        check("rst_bus_valid", W'(p1_bus_valid), 32'h0);
        check("rst_cnt", W'(p1_cnt), 32'h0);
        clear = 1'b1;

        // Basic select; the PIPE=0 instance shows it before the edge.
        set_slot(5, 32'hDEAD_BEEF);
        src_out = 24'(1) << 5;
        #1;
        check("p0_zero_latency", p0_bus_out, 32'hDEAD_BEEF);
        cycle();
        check("sel5_out", p1_bus_out, 32'hDEAD_BEEF);
        check("sel5_sel", W'(p1_bus_sel), 32'd5);
        check("sel5_valid", W'(p1_bus_valid), 32'd1);

        set_slot(23, 32'hFFFF_FFF0);
        src_out = 24'(1) << 23;
        cycle();
        check("sel23_sel", W'(p1_bus_sel), 32'd23);
        check("sel23_out", p1_bus_out, 32'hFFFF_FFF0);

        // Multi-driver: lowest index wins and the conflict pulse lasts one cycle.
        src_out = (24'(1) << 2) | (24'(1) << 20);
        cycle();
        check("multi_sel", W'(p1_bus_sel), 32'd2);
        check("multi_conflict", W'(p1_conflict), 32'd1);
        check("multi_flag", W'(p1_flag), 32'd1);
        src_out = 24'(1) << 2;
        cycle();
        check("multi_pulse_end", W'(p1_conflict), 32'd0);

        src_out = (24'(1) << 2) | (24'(1) << 20);
        repeat (300) cycle();
        check("cnt_saturate", W'(p1_cnt), 32'd255);

        // Unpopulated slot alone.
        src_out = 24'(1) << 22;
        cycle();
        check("hole_out", p1_bus_out, 32'h0);
        check("hole_valid", W'(p1_bus_valid), 32'd0);
        check("hole_conflict", W'(p1_conflict), 32'd1);

        // Clear coinciding with a new conflict, then clear alone.
        conflict_clr = 1'b1;
        src_out = (24'(1) << 2) | (24'(1) << 20);
        cycle();
        check("clr_set_flag", W'(p1_flag), 32'd1);
        check("clr_set_cnt", W'(p1_cnt), 32'd1);
        src_out = 24'(1) << 1;
        cycle();
        check("clr_only_cnt", W'(p1_cnt), 32'd0);
        check("clr_only_flag", W'(p1_flag), 32'd0);
        conflict_clr = 1'b0;

        // Hold freezes the bus; release resumes in the same cycle.
        set_slot(20, 32'h10);
        src_out = 24'(1) << 20;
        cycle();
        check("pc_out", p1_bus_out, 32'h10);
        hold = 1'b1;
        set_slot(20, 32'h14);
        set_slot(21, 32'hCAFE_0021);
        src_out = 24'(1) << 21;
        cycle();
        check("hold_p1_out", p1_bus_out, 32'h10);
        check("hold_p0_out", p0_bus_out, 32'h10);
        hold = 1'b0;
        cycle();
        check("release_out", p1_bus_out, 32'hCAFE_0021);
        check("release_sel", W'(p1_bus_sel), 32'd21);

        // X on unselected slots must not leak.
        for (int i = 0; i < 5; i++) set_slot(i, 'x);
        set_slot(6, 'x);
        src_out = 24'(1) << 5;
        cycle();
        check("x_isolation", p1_bus_out, 32'hDEAD_BEEF);
        fill_random();

        // Reset while holding.
        src_out = 24'(1) << 7;
        cycle();
        hold = 1'b1;
        clear = 1'b0;
        cycle();
        check("rst_hold_out", p1_bus_out, 32'h0);
        check("rst_hold_valid", W'(p1_bus_valid), 32'd0);
        check("rst_hold_sel", W'(p1_bus_sel), 32'd0);
        clear = 1'b1;
        src_out = 24'(1) << 8;
        cycle();
        check("rst_hold_p0_out", p0_bus_out, 32'h0);
        hold = 1'b0;

        // Randomized traffic against the model.
        repeat (400) begin
            fill_random();
            r = $urandom_range(0, 3);
            case (r)
                0: src_out = '0;
                1: src_out = 24'(1) << $urandom_range(0, N - 1);
                2: src_out = (24'(1) << $urandom_range(0, N - 1)) | (24'(1) << $urandom_range(0, N - 1));
                default: src_out = 24'($urandom);
            endcase
            hold         = ($urandom_range(0, 4) == 0);
            conflict_clr = ($urandom_range(0, 7) == 0);
            clear        = ($urandom_range(0, 39) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
